// File: rtl/mode_input_conditioner.sv
// Front-end conditioner: synchronises and debounces the mode switches and start/stop buttons,
// then drives the control path's mode request and start level.
module mode_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sw_mode,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic [1:0]       regime,
  input  logic             active,
  output logic [1:0]       on,
  output logic             start,
  output logic [CNT_W-1:0] start_count
);

  localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Bit order: {stop, start, mode[1:0]}
  logic [3:0] w_raw;
  logic [3:0] w_stable;

  assign w_raw = {btn_stop, btn_start, sw_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_db
      logic             r_s1;
      logic             r_s2;
      logic             r_stable;
      logic [CNT_W-1:0] r_dc;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1     <= 1'b0;
          r_s2     <= 1'b0;
          r_stable <= 1'b0;
          r_dc     <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_stable) begin
            r_dc <= '0;
          end else if (r_dc == DC_LAST) begin
            r_stable <= r_s2;
            r_dc     <= '0;
          end else begin
            r_dc <= r_dc + CNT_ONE;
          end
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  logic [1:0]       r_stable_d;   // previous debounced {stop, start}
  logic             r_active_d;
  logic [1:0]       r_on;
  logic             r_start;
  logic [CNT_W-1:0] r_start_count;

  logic [1:0] w_mode;
  logic       w_rise_start;
  logic       w_rise_stop;
  logic       w_act_fall;
  logic       w_mode_chg;
  logic       w_start_next;

  assign w_mode       = w_stable[1:0];
  assign w_rise_start = w_stable[2] & ~r_stable_d[0];
  assign w_rise_stop  = w_stable[3] & ~r_stable_d[1];
  assign w_act_fall   = r_active_d & ~active;
  assign w_mode_chg   = (w_mode != r_on);

  // Clear conditions are checked first so they always win over a same-cycle set.
  always_comb begin
    w_start_next = r_start;
    if (w_rise_stop) begin
      w_start_next = 1'b0;
    end else if (w_act_fall) begin
      w_start_next = 1'b0;
    end else if (w_mode_chg && (regime != 2'd0)) begin
      w_start_next = 1'b0;
    end else if (w_rise_start && (w_mode != 2'd0)) begin
      w_start_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable_d    <= 2'b00;
      r_active_d    <= 1'b0;
      r_on          <= 2'd0;
      r_start       <= 1'b0;
      r_start_count <= '0;
    end else begin
      r_stable_d <= w_stable[3:2];
      r_active_d <= active;
      r_on       <= w_mode;
      r_start    <= w_start_next;
      if (w_start_next && !r_start && (r_start_count != CNT_MAX)) begin
        r_start_count <= r_start_count + CNT_ONE;
      end
    end
  end

  assign on          = r_on;
  assign start       = r_start;
  assign start_count = r_start_count;

endmodule
